pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Measures an external PWM waveform and reports its period and high time in CLK cycles.
- Receive-side counterpart of the PWM generator: the generator takes period/duty words from Nios PIOs; this block drives measured period/high-time words back into Nios PIO inputs.
- Used for loopback self-test of the generator and for measuring external PWM sources on DE1 GPIO.

Parameters:
- WIDTH, 28, width of the counter and of the PERIOD/HIGH_TIME outputs.
- TIMEOUT_CYCLES, 100000000, cycles without an edge before the input is declared stuck (1 s at 100 MHz); legal range 2..2^WIDTH-1.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST_N  input  1  reset, asynchronous, active-low.
- EN  input  1  measurement enable, from a Nios PIO.
- PWM_IN  input  1  asynchronous PWM input.
- PERIOD  output  WIDTH  last measured period in cycles, rising edge to rising edge.
- HIGH_TIME  output  WIDTH  last measured high time in cycles.
- VALID  output  1  one-cycle strobe when PERIOD/HIGH_TIME/TIMEOUT update.
- TIMEOUT  output  1  sticky flag: no edge seen for TIMEOUT_CYCLES.
- STUCK_LEVEL  output  1  synchronized PWM level captured at timeout.

Behaviour:
- Reset (async, RST_N=0):
  - sync0, sync1, prev = 0.
  - cnt = 0, high_lat = 0, state = WAIT_RISE.
  - PERIOD = 0, HIGH_TIME = 0, VALID = 0, TIMEOUT = 0, STUCK_LEVEL = 0.
- Input synchronizer and edge detect:
  - PWM_IN passes through a 2-FF synchronizer (sync0 -> sync1); prev <= sync1.
  - rise = sync1 & ~prev; fall = ~sync1 & prev.
  - rise and fall are mutually exclusive by construction.
- State machine (states WAIT_RISE, MEAS_HIGH, MEAS_LOW):
  - WAIT_RISE: cnt held. On rise: cnt <= 1, go to MEAS_HIGH. The partial first period after reset, enable or timeout is discarded.
  - MEAS_HIGH: cnt <= cnt+1 each cycle. On fall: high_lat <= cnt, cnt <= cnt+1, go to MEAS_LOW.
  - MEAS_LOW: cnt <= cnt+1 each cycle. On rise: PERIOD <= cnt, HIGH_TIME <= high_lat, VALID <= 1, TIMEOUT <= 0, cnt <= 1, go to MEAS_HIGH.
- Counter values:
  - A waveform high for H synchronized cycles and low for L cycles yields HIGH_TIME = H, PERIOD = H+L.
  - Minimum measurable values: H = 1, L = 1, so PERIOD = 2.
- Timeout:
  - Applies in MEAS_HIGH or MEAS_LOW when cnt == TIMEOUT_CYCLES and no edge occurs that cycle.
  - Actions: PERIOD <= 0, HIGH_TIME <= 0, TIMEOUT <= 1, STUCK_LEVEL <= sync1, VALID <= 1 (single strobe), go to WAIT_RISE.
  - No further VALID strobes until a full new period completes.
  - If an edge coincides with cnt == TIMEOUT_CYCLES, the edge wins and no timeout occurs.
- Counter saturation: cnt never wraps. TIMEOUT_CYCLES < 2^WIDTH guarantees the timeout fires before overflow.
- EN = 0:
  - Synchronous force to WAIT_RISE with cnt <= 0.
  - PERIOD, HIGH_TIME, TIMEOUT and STUCK_LEVEL hold their values; VALID = 0.
  - The synchronizer keeps running.
  - After EN returns to 1, the first rise starts a new measurement; no VALID until a complete period.
- VALID timing:
  - VALID is registered and high exactly one cycle.
  - PERIOD and HIGH_TIME are stable from the VALID cycle until the next update.
- Latency: PWM_IN rising edge to VALID is 3 to 4 CLK edges (synchronizer uncertainty). Measured values are unaffected because both edges see equal delay.
- Reset mid-measurement: all state cleared as in reset; the in-progress period is discarded.
- Simultaneous cases:
  - A rise in MEAS_LOW on the same cycle that EN drops: EN wins, no VALID.
  - RST_N overrides everything.

Test Plan:
- After reset, drive PWM_IN high 3 / low 5 cycles repeatedly with EN=1 -> first VALID only after the second rising edge; PERIOD=8, HIGH_TIME=3; VALID one cycle every 8 cycles thereafter.
- Change the waveform to high 1 / low 1 -> first complete new period gives PERIOD=2, HIGH_TIME=1; also check high 7 / low 1 -> PERIOD=8, HIGH_TIME=7.
- TIMEOUT_CYCLES=100, hold PWM_IN high after a valid period -> single VALID with PERIOD=0, HIGH_TIME=0, TIMEOUT=1, STUCK_LEVEL=1. Resuming 4/4 toggling -> next VALID gives PERIOD=8, HIGH_TIME=4, TIMEOUT=0.
- Drop EN mid-period, hold 20 cycles, restore -> no VALID while EN=0, previous PERIOD held; first post-enable VALID reflects a full period only.
- Pulse RST_N low mid-MEAS_LOW -> all outputs 0 immediately (async); the partial period is discarded; measurement resumes after two rising edges.
- Loopback with the PWM generator at period 1000, decode 250 -> PERIOD=1000, HIGH_TIME=250 on every VALID across at least 10 periods.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM input in CLK cycles.
// Results are strobed by VALID; TIMEOUT and STUCK_LEVEL report a stalled input.
module pwm_capture #(
    parameter int unsigned WIDTH          = 28,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             PWM_IN,
    output logic [WIDTH-1:0] PERIOD,
    output logic [WIDTH-1:0] HIGH_TIME,
    output logic             VALID,
    output logic             TIMEOUT,
    output logic             STUCK_LEVEL
);

    localparam logic [WIDTH-1:0] TIMEOUT_VAL = WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t           state;
    logic             sync0;
    logic             sync1;
    logic             prev;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] high_lat;
    logic             rise;
    logic             fall;
    logic             at_timeout;

    always_comb begin
        rise       = sync1 & ~prev;
        fall       = ~sync1 & prev;
        at_timeout = (cnt == TIMEOUT_VAL);
        cnt_inc    = (cnt == '1) ? cnt : cnt + CNT_ONE;
    end

    // Synchronizer runs regardless of EN so edge detection is clean on re-enable.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync0 <= PWM_IN;
            sync1 <= sync0;
            prev  <= sync1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= WAIT_RISE;
            cnt         <= '0;
            high_lat    <= '0;
            PERIOD      <= '0;
            HIGH_TIME   <= '0;
            VALID       <= 1'b0;
            TIMEOUT     <= 1'b0;
            STUCK_LEVEL <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (!EN) begin
                state <= WAIT_RISE;
                cnt   <= '0;
            end else begin
                case (state)
                    WAIT_RISE: begin
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            state <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH, MEAS_LOW: begin
                        // Edge tests come before the timeout test so an edge on the
                        // terminal count is still measured.
                        if (state == MEAS_HIGH && fall) begin
                            high_lat <= cnt;
                            cnt      <= cnt_inc;
                            state    <= MEAS_LOW;
                        end else if (state == MEAS_LOW && rise) begin
                            PERIOD    <= cnt;
                            HIGH_TIME <= high_lat;
                            VALID     <= 1'b1;
                            TIMEOUT   <= 1'b0;
                            cnt       <= CNT_ONE;
                            state     <= MEAS_HIGH;
                        end else if (at_timeout) begin
                            PERIOD      <= '0;
                            HIGH_TIME   <= '0;
                            TIMEOUT     <= 1'b1;
                            STUCK_LEVEL <= sync1;
                            VALID       <= 1'b1;
                            state       <= WAIT_RISE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= WAIT_RISE;
                endcase
            end
        end
    end

endmodule
